// File: rtl/fog_loop_sequencer.sv
// FOG closed-loop start-up / gain-scheduling sequencer.
// Holds the loop open while the front end settles, closes it with coarse
// gains, switches to fine gains once the error stays in band, and falls
// back to coarse gains (counting the event) when lock is lost.
module fog_loop_sequencer #(
    parameter int unsigned SETTLE_CNT = 1000,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_trig,
    input  logic [31:0] i_err,
    input  logic [31:0] i_err_th,
    input  logic [31:0] i_gain_coarse_step,
    input  logic [31:0] i_gain_fine_step,
    input  logic [31:0] i_gain_coarse_ramp,
    input  logic [31:0] i_gain_fine_ramp,
    output logic        o_fb_ON,
    output logic [31:0] o_gainSel_step,
    output logic [31:0] o_gainSel_ramp,
    output logic [1:0]  o_state,
    output logic        o_locked,
    output logic [15:0] o_relock_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACQUIRE = 2'd2,
        TRACK   = 2'd3
    } state_t;

    // A settle length of 0 behaves like 1.
    localparam int unsigned SETTLE_EFF  = (SETTLE_CNT == 0) ? 1 : SETTLE_CNT;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);
    localparam logic [15:0] LOCK_TGT    = 16'(LOCK_CNT);
    localparam logic [15:0] UNLOCK_TGT  = 16'(UNLOCK_CNT);

    state_t      state, state_nxt;
    logic [31:0] settle_cnt, settle_nxt;
    logic [15:0] in_cnt, in_nxt, out_cnt, out_nxt, relock_nxt;
    logic [15:0] in_inc, out_inc;
    logic [31:0] abs_err;
    logic        in_band;

    assign o_state = state;

    // |i_err| with the most negative value saturated, then unsigned band compare
    always_comb begin
        abs_err = i_err[31] ? (~i_err + 32'd1) : i_err;
        if (i_err == 32'h8000_0000) abs_err = 32'h7FFF_FFFF;
        in_band = (abs_err <= i_err_th);
        in_inc  = (in_cnt  == 16'hFFFF) ? in_cnt  : in_cnt  + 16'd1;
        out_inc = (out_cnt == 16'hFFFF) ? out_cnt : out_cnt + 16'd1;
    end

    // Next-state and counter updates; dropping i_start overrides everything
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        in_nxt     = in_cnt;
        out_nxt    = out_cnt;
        relock_nxt = o_relock_cnt;
        if (!i_start) begin
            state_nxt  = IDLE;
            settle_nxt = '0;
            in_nxt     = '0;
            out_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state_nxt = ACQUIRE;
                    settle_nxt = settle_cnt + 32'd1;
                end
                ACQUIRE: begin
                    if (i_trig) begin
                        if (!in_band) begin
                            in_nxt = '0;
                        end else if (in_inc >= LOCK_TGT) begin
                            state_nxt = TRACK;
                            in_nxt    = '0;
                            out_nxt   = '0;
                        end else begin
                            in_nxt = in_inc;
                        end
                    end
                end
                TRACK: begin
                    if (i_trig) begin
                        if (in_band) begin
                            out_nxt = '0;
                        end else if (out_inc >= UNLOCK_TGT) begin
                            state_nxt  = ACQUIRE;
                            in_nxt     = '0;
                            out_nxt    = '0;
                            relock_nxt = (o_relock_cnt == 16'hFFFF) ? o_relock_cnt
                                                                    : o_relock_cnt + 16'd1;
                        end else begin
                            out_nxt = out_inc;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters and Moore outputs, all following the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            in_cnt         <= '0;
            out_cnt        <= '0;
            o_relock_cnt   <= '0;
            o_fb_ON        <= 1'b0;
            o_locked       <= 1'b0;
            o_gainSel_step <= '0;
            o_gainSel_ramp <= '0;
        end else begin
            state          <= state_nxt;
            settle_cnt     <= settle_nxt;
            in_cnt         <= in_nxt;
            out_cnt        <= out_nxt;
            o_relock_cnt   <= relock_nxt;
            o_fb_ON        <= (state_nxt == ACQUIRE) || (state_nxt == TRACK);
            o_locked       <= (state_nxt == TRACK);
            o_gainSel_step <= (state_nxt == TRACK) ? i_gain_fine_step : i_gain_coarse_step;
            o_gainSel_ramp <= (state_nxt == TRACK) ? i_gain_fine_ramp : i_gain_coarse_ramp;
        end
    end

endmodule

// File: tb/tb_fog_loop_sequencer.sv
// Self-checking bench for fog_loop_sequencer: directed scenarios plus a
// random soak, all compared against a cycle-level behavioural model.
module tb_fog_loop_sequencer;

    localparam int SETTLE = 10;
    localparam int LOCK   = 16;
    localparam int UNLOCK = 4;

    logic        i_clk = 1'b0, i_rst_n = 1'b1, i_start = 1'b0, i_trig = 1'b0;
    logic [31:0] i_err = '0, i_err_th = '0;
    logic [31:0] gcs = '0, gfs = '0, gcr = '0, gfr = '0;
    logic        o_fb_ON, o_locked;
    logic [31:0] o_gainSel_step, o_gainSel_ramp;
    logic [1:0]  o_state;
    logic [15:0] o_relock_cnt;

    int checks = 0;
    int passes = 0;

    // model: state as a number, streak lengths, cycles spent settling
    int          m_state = 0, m_settle = 0, m_in = 0, m_out = 0;
    logic [15:0] m_rel = '0;
    logic [31:0] m_step = '0, m_ramp = '0;

    fog_loop_sequencer #(.SETTLE_CNT(SETTLE), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_trig(i_trig),
        .i_err(i_err), .i_err_th(i_err_th),
        .i_gain_coarse_step(gcs), .i_gain_fine_step(gfs),
        .i_gain_coarse_ramp(gcr), .i_gain_fine_ramp(gfr),
        .o_fb_ON(o_fb_ON), .o_gainSel_step(o_gainSel_step), .o_gainSel_ramp(o_gainSel_ramp),
        .o_state(o_state), .o_locked(o_locked), .o_relock_cnt(o_relock_cnt)
    );

    always #5 i_clk = ~i_clk;

    wire [83:0] dut_vec = {o_fb_ON, o_state, o_locked, o_relock_cnt, o_gainSel_step, o_gainSel_ramp};

    function automatic logic [83:0] exp_vec();
        return {(m_state >= 2), 2'(m_state), (m_state == 3), m_rel, m_step, m_ramp};
    endfunction

    function automatic bit is_in_band(input logic [31:0] e, input logic [31:0] th);
        logic signed [31:0] se;
        longint a;
        se = e;
        a  = se;
        if (a < 0) a = -a;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        return a <= longint'({32'd0, th});
    endfunction

    function automatic logic [31:0] rand_in();
        int v;
        v = $urandom_range(0, 50);
        if ($urandom_range(0, 1) == 1) v = -v;
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_settle = 0; m_in = 0; m_out = 0;
        m_rel = '0; m_step = '0; m_ramp = '0;
    endtask

    // advance one clock; the model sees the inputs present at the edge
    task automatic tick();
        bit          st, tg, inb;
        int          nxt;
        logic [31:0] cs, fs, cr, fr;
        st = i_start; tg = i_trig; inb = is_in_band(i_err, i_err_th);
        cs = gcs; fs = gfs; cr = gcr; fr = gfr;
        @(posedge i_clk);
        if (i_rst_n) begin
            nxt = m_state;
            if (!st) begin
                nxt = 0; m_settle = 0; m_in = 0; m_out = 0;
            end else if (m_state == 0) begin
                nxt = 1; m_settle = 0;
            end else if (m_state == 1) begin
                m_settle++;
                if (m_settle >= SETTLE) nxt = 2;
            end else if (m_state == 2 && tg) begin
                m_in = inb ? m_in + 1 : 0;
                if (m_in == LOCK) begin nxt = 3; m_in = 0; m_out = 0; end
            end else if (m_state == 3 && tg) begin
                m_out = inb ? 0 : m_out + 1;
                if (m_out == UNLOCK) begin
                    nxt = 2; m_in = 0; m_out = 0;
                    if (m_rel != 16'hFFFF) m_rel++;
                end
            end
            m_state = nxt;
            m_step  = (nxt == 3) ? fs : cs;
            m_ramp  = (nxt == 3) ? fr : cr;
        end
        #1;
    endtask

    task automatic trig(input logic [31:0] e);
        i_trig = 1'b1; i_err = e;
        tick();
        i_trig = 1'b0; i_err = $urandom;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        #1 i_rst_n = 1'b0;
        model_reset();
        #2;
        checks++; if (dut_vec !== 84'd0) $display("FAIL reset_async: got %h exp 0", dut_vec); else passes++;
        tick();
        checks++; if (dut_vec !== 84'd0) $display("FAIL reset_held: got %h exp 0", dut_vec); else passes++;
        i_rst_n = 1'b1;
        gcs = 32'd5; gcr = 32'd7; gfs = 32'd2; gfr = 32'd3;
        tick();
        checks++; if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h exp %h", dut_vec, exp_vec()); else passes++;
    endtask

    task automatic run_settle(input string name);
        int cnt;
        i_start = 1'b1;
        tick();
        cnt = 0;
        while (o_state == 2'd1 && cnt < 50) begin
            cnt++;
            checks++; if (dut_vec !== exp_vec()) $display("FAIL %s_cycle: got %h exp %h", name, dut_vec, exp_vec()); else passes++;
            tick();
        end
        checks++; if (cnt !== SETTLE) $display("FAIL %s_len: got %0d exp %0d", name, cnt, SETTLE); else passes++;
        checks++; if (dut_vec !== exp_vec() || o_state !== 2'd2 || o_fb_ON !== 1'b1)
            $display("FAIL %s_exit: got %h exp %h", name, dut_vec, exp_vec()); else passes++;
    endtask

    task automatic test_settle();
        run_settle("settle");
        checks++; if (o_gainSel_step !== 32'd5 || o_gainSel_ramp !== 32'd7)
            $display("FAIL settle_gains: got %0d/%0d exp 5/7", o_gainSel_step, o_gainSel_ramp); else passes++;
    endtask

    task automatic test_lock();
        i_err_th = 32'd100;
        for (int i = 0; i < LOCK; i++) begin
            trig(rand_in());
            checks++; if (dut_vec !== exp_vec() || o_state !== ((i == LOCK - 1) ? 2'd3 : 2'd2))
                $display("FAIL lock_trig%0d: got %h exp %h", i, dut_vec, exp_vec()); else passes++;
            idle($urandom_range(0, 2));
        end
        checks++; if (o_locked !== 1'b1 || o_gainSel_step !== 32'd2 || o_gainSel_ramp !== 32'd3)
            $display("FAIL lock_fine: got %b %0d/%0d exp 1 2/3", o_locked, o_gainSel_step, o_gainSel_ramp); else passes++;
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 8; i++) begin
            trig((i == 3) ? rand_in() : 32'd500);
            checks++; if (dut_vec !== exp_vec() || o_state !== ((i == 7) ? 2'd2 : 2'd3))
                $display("FAIL unlock_trig%0d: got %h exp %h", i, dut_vec, exp_vec()); else passes++;
            idle($urandom_range(0, 2));
        end
        checks++; if (o_relock_cnt !== 16'd1) $display("FAIL unlock_relock: got %0d exp 1", o_relock_cnt); else passes++;
    endtask

    task automatic test_lock_restart();
        for (int i = 0; i < 10 + LOCK; i++) begin
            if (i == 9) trig(32'd101);
            else if (i == 9 + LOCK) trig(-32'sd100);
            else trig(rand_in());
            checks++; if (dut_vec !== exp_vec() || o_state !== ((i == 9 + LOCK) ? 2'd3 : 2'd2))
                $display("FAIL restart_trig%0d: got %h exp %h", i, dut_vec, exp_vec()); else passes++;
        end
    endtask

    task automatic test_abs_edge();
        i_err_th = 32'h7FFF_FFFE;
        for (int i = 0; i < UNLOCK; i++) begin
            trig(32'h8000_0000);
            checks++; if (dut_vec !== exp_vec() || o_state !== ((i == UNLOCK - 1) ? 2'd2 : 2'd3))
                $display("FAIL abs_out%0d: got %h exp %h", i, dut_vec, exp_vec()); else passes++;
        end
        i_err_th = 32'h7FFF_FFFF;
        for (int i = 0; i < LOCK; i++) begin
            trig(32'h8000_0000);
            checks++; if (dut_vec !== exp_vec() || o_state !== ((i == LOCK - 1) ? 2'd3 : 2'd2))
                $display("FAIL abs_in%0d: got %h exp %h", i, dut_vec, exp_vec()); else passes++;
        end
        i_err_th = 32'd100;
    endtask

    task automatic test_start_drop();
        i_start = 1'b0;
        trig(32'd500);
        checks++; if (dut_vec !== exp_vec() || o_state !== 2'd0 || o_fb_ON !== 1'b0 || o_relock_cnt !== 16'd2)
            $display("FAIL drop_idle: got %h exp %h", dut_vec, exp_vec()); else passes++;
        run_settle("resettle");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) trig(rand_in());
        #2 i_rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (dut_vec !== 84'd0 || o_relock_cnt !== 16'd0)
            $display("FAIL async_reset: got %h exp 0", dut_vec); else passes++;
        #1 i_rst_n = 1'b1;
        tick();
        checks++; if (dut_vec !== exp_vec()) $display("FAIL async_release: got %h exp %h", dut_vec, exp_vec()); else passes++;
    endtask

    task automatic test_random();
        int bias;
        bias = 95;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) bias = (bias == 95) ? 40 : 95;
            i_start = ($urandom_range(0, 299) != 0);
            i_trig  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) i_err_th = $urandom_range(0, 1000);
            if ($urandom_range(0, 199) == 0) i_err = 32'h8000_0000;
            else if ($urandom_range(0, 99) < bias) i_err = 32'($urandom_range(0, 40)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
            else i_err = 32'($urandom_range(1001, 5000)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
            if ($urandom_range(0, 7) == 0) begin gcs = $urandom; gfs = $urandom; gcr = $urandom; gfr = $urandom; end
            tick();
            checks++; if (dut_vec !== exp_vec()) $display("FAIL random_c%0d: got %h exp %h", c, dut_vec, exp_vec()); else passes++;
        end
        i_trig = 1'b0;
    endtask

    initial begin
        test_reset();
        test_settle();
        test_lock();
        test_unlock();
        test_lock_restart();
        test_abs_edge();
        test_start_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fog_loop_sequencer.md
Name: fog_loop_sequencer

Overview:
- Closed-loop start-up and gain-scheduling controller for the FOG signal chain.
- Drives the feedback-enable and the step/ramp gain selects into the feedback step generator and phase ramp generator.
- Sequence: hold the loop open while the ADC FIR and modulation settle, close with coarse gains, then switch to fine gains once the error stays in band.
- Falls back to coarse gains when lock is lost, and counts relock events for the CPU.

Parameters:
SETTLE_CNT, 1000, i_clk cycles in SETTLE before the loop is closed; a value of 0 is treated as 1.
LOCK_CNT, 16, consecutive in-band triggers required to go from ACQUIRE to TRACK; must be ≥1.
UNLOCK_CNT, 4, consecutive out-of-band triggers required to go from TRACK back to ACQUIRE; must be ≥1.

Ports:
i_clk  in  1  system clock (DAC clock domain)
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  CPU run enable (level)
i_trig  in  1  one-cycle error-valid pulse (step sync from the error generator)
i_err  in  32  signed error (FIR-filtered error), sampled only when i_trig=1
i_err_th  in  32  unsigned in-band threshold
i_gain_coarse_step  in  32  step gain select used in ACQUIRE
i_gain_fine_step  in  32  step gain select used in TRACK
i_gain_coarse_ramp  in  32  ramp gain select used in ACQUIRE
i_gain_fine_ramp  in  32  ramp gain select used in TRACK
o_fb_ON  out  1  feedback enable
o_gainSel_step  out  32  step gain select
o_gainSel_ramp  out  32  ramp gain select
o_state  out  2  IDLE=0, SETTLE=1, ACQUIRE=2, TRACK=3
o_locked  out  1  1 iff state is TRACK
o_relock_cnt  out  16  count of TRACK→ACQUIRE falls, saturating

Behaviour:
- Reset (asynchronous): state=IDLE; all counters, all outputs and o_relock_cnt are 0.
- All outputs are registered and updated on the same edge as the state (Moore).
- Gain outputs:
  - IDLE, SETTLE, ACQUIRE: the coarse inputs.
  - TRACK: the fine inputs.
  - The selected input value appears on the output 1 cycle after it is applied, including live changes to the gain inputs.
  - Exception: the gain outputs stay 0 from reset until the first clock edge.
- o_fb_ON: 0 in IDLE and SETTLE; 1 in ACQUIRE and TRACK.
- abs_err: |i_err|, with -2^31 saturating to 2^31-1. In-band means abs_err ≤ i_err_th (unsigned compare).
- IDLE: move to SETTLE on any edge where i_start=1. The settle counter is cleared.
- SETTLE:
  - The settle counter increments every cycle.
  - When it equals max(SETTLE_CNT,1)-1, move to ACQUIRE on that edge. With SETTLE_CNT=1000, the state is in SETTLE for exactly 1000 cycles.
  - i_trig is ignored.
- ACQUIRE:
  - On each i_trig: in-band increments in_cnt; out-of-band clears in_cnt.
  - The trig that makes in_cnt reach LOCK_CNT moves the state to TRACK on the same edge. in_cnt and out_cnt are then cleared.
- TRACK:
  - On each i_trig: out-of-band increments out_cnt; in-band clears out_cnt.
  - The trig that makes out_cnt reach UNLOCK_CNT moves the state to ACQUIRE on the same edge.
  - On that edge o_relock_cnt increments, holding at 0xFFFF; in_cnt and out_cnt are cleared.
- i_start=0 in any state: the next edge goes to IDLE and all sequencing counters are cleared. This has priority over every other transition, including a simultaneous i_trig.
- o_relock_cnt is cleared only by reset; it is retained through IDLE.
- Cycles with no i_trig leave in_cnt and out_cnt unchanged; there is no timeout.
- Counter widths:
  - Settle counter: 32 bits.
  - in_cnt and out_cnt: 16 bits, saturating; they cannot overflow because they are cleared on transition.
- Reset asserted mid-sequence immediately forces the reset values, independent of the clock.

Test Plan:
- Reset, then i_start=1, SETTLE_CNT=10, coarse gains 5/7, fine 2/3 → o_state=1 for exactly 10 cycles, then o_state=2 with o_fb_ON=1 and gains 5/7.
- In ACQUIRE, i_err_th=100; apply 16 trigs with i_err=±50 → on the 16th trig edge o_state=3, o_locked=1, gains 2/3. Repeat with the 10th trig at i_err=101 → lock requires 16 more in-band trigs after it.
- In TRACK, apply 3 trigs with i_err=500, 1 in-band, then 4 at 500 → stays TRACK until the 4th consecutive out-of-band trig, then o_state=2, o_relock_cnt=1.
- i_err=0x80000000 with i_err_th=0x7FFFFFFF → in-band. With i_err_th=0x7FFFFFFE → out-of-band.
- In TRACK, drop i_start together with an i_trig → next edge o_state=0, o_fb_ON=0, o_relock_cnt unchanged. Raise i_start → SETTLE restarts from count 0.
- Pulse i_rst_n low mid-ACQUIRE without a clock edge → outputs are 0 immediately, o_relock_cnt=0.
